// File: rtl/conv3x3_mac_tree_pkg.sv
// conv3x3_mac_tree_pkg: shared constants for the 3x3 MAC core.
// Operand/result width, fixed-point scaling and saturation bounds.
package conv3x3_mac_tree_pkg;

  localparam int CONV_WIDTH   = 9;
  localparam int CONV_FRAC    = 4;
  localparam int CONV_PROD_W  = 2 * CONV_WIDTH;
  localparam int CONV_SUM_W   = 2 * CONV_WIDTH + 4;
  localparam int CONV_SAT_MAX = 2 ** (CONV_WIDTH - 1) - 1;
  localparam int CONV_SAT_MIN = -(2 ** (CONV_WIDTH - 1));
  localparam int CONV_TAPS    = 9;
  localparam int CONV_LAT     = 6;

endpackage

// File: rtl/conv_mul.sv
// conv_mul: signed WIDTH x WIDTH multiplier, registered
// full-precision product.
module conv_mul
  import conv3x3_mac_tree_pkg::*;
#(
  parameter int WIDTH = CONV_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else begin
      p <= PW'(a) * PW'(b);
    end
  end

endmodule

// File: rtl/conv3x3_mac_tree.sv
// conv3x3_mac_tree: nine-tap signed MAC with registered adder
// tree, arithmetic rescale and saturation; fixed 6-cycle latency.
module conv3x3_mac_tree
  import conv3x3_mac_tree_pkg::*;
#(
  parameter int WIDTH = CONV_WIDTH,
  parameter int FRAC  = CONV_FRAC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [9*WIDTH-1:0]     a,
  input  logic [9*WIDTH-1:0]     b,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int SUM_W  = 2 * WIDTH + 4;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    SUM_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [PROD_W-1:0] p [CONV_TAPS];
  logic signed [SUM_W-1:0]  s2 [5];
  logic signed [SUM_W-1:0]  s3 [3];
  logic signed [SUM_W-1:0]  s4 [2];
  logic signed [SUM_W-1:0]  s5;
  logic signed [SUM_W-1:0]  scaled;
  logic        [WIDTH-1:0]  sat_res;
  logic        [CONV_LAT-1:0] vld;

  for (genvar k = 0; k < CONV_TAPS; k++) begin : g_mul
    conv_mul #(
      .WIDTH (WIDTH)
    ) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a[k*WIDTH +: WIDTH]),
      .b     (b[k*WIDTH +: WIDTH]),
      .p     (p[k])
    );
  end

  always_comb begin
    scaled  = s5 >>> FRAC;
    sat_res = scaled[WIDTH-1:0];
    if (scaled > SAT_MAX) begin
      sat_res = SAT_MAX[WIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      sat_res = SAT_MIN[WIDTH-1:0];
    end
  end

  // Data stages run freely; only the valid chain qualifies them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      s2  <= '{default: '0};
      s3  <= '{default: '0};
      s4  <= '{default: '0};
      s5  <= '0;
      out <= '0;
    end else begin
      vld <= {vld[CONV_LAT-2:0], in_valid};
      for (int i = 0; i < 4; i++) begin
        s2[i] <= SUM_W'(p[2*i]) + SUM_W'(p[2*i+1]);
      end
      s2[4] <= SUM_W'(p[8]);
      s3[0] <= s2[0] + s2[1];
      s3[1] <= s2[2] + s2[3];
      s3[2] <= s2[4];
      s4[0] <= s3[0] + s3[1];
      s4[1] <= s3[2];
      s5    <= s4[0] + s4[1];
      if (vld[CONV_LAT-2]) begin
        out <= sat_res;
      end
    end
  end

  assign out_valid = vld[CONV_LAT-1];

endmodule

// File: tb/tb_conv3x3_mac_tree.sv
// tb_conv3x3_mac_tree: directed and randomized checks of the
// 3x3 MAC core against an integer reference model.
module tb_conv3x3_mac_tree;

  localparam int W = 9;

  typedef logic [W-1:0] win_t [9];

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [9*W-1:0] a;
  logic [9*W-1:0] b;
  logic           out_valid;
  logic [W-1:0]   out;

  int n_cmp;
  int n_bad;
  logic [W-1:0] model_out;

  conv3x3_mac_tree dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9*W-1:0] pack(input win_t w);
    logic [9*W-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*W +: W] = w[k];
    return r;
  endfunction

  // Exact dot product, floor-divide by 16, clamp to 9-bit signed.
  function automatic logic [W-1:0] ref_out(input win_t wa,
                                            input win_t wb);
    int sum;
    int q;
    int r;
    sum = 0;
    for (int k = 0; k < 9; k++) begin
      sum += int'($signed(wa[k])) * int'($signed(wb[k]));
    end
    r = ((sum % 16) + 16) % 16;
    q = (sum - r) / 16;
    if (q > 255) q = 255;
    if (q < -256) q = -256;
    return q[W-1:0];
  endfunction

  function automatic win_t rand_win();
    win_t w;
    for (int k = 0; k < 9; k++) w[k] = W'($urandom_range(0, 511));
    return w;
  endfunction

  // Drives one valid set and leaves the bench six edges later.
  task automatic apply_one(input win_t wa, input win_t wb);
    @(negedge clk);
    a = pack(wa);
    b = pack(wb);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    a = '0;
    b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out !== 9'd0 || out_valid !== 1'b0) begin
      $display("FAIL reset_state: out=%h out_valid=%b need 000/0",
               out, out_valid);
      n_bad++;
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_idle: out_valid=%b need 0", out_valid);
      n_bad++;
    end
    model_out = '0;
  endtask

  task automatic test_unity();
    win_t wa;
    win_t wb;
    logic [W-1:0] e;
    for (int k = 0; k < 9; k++) begin
      wa[k] = 9'd16;
      wb[k] = 9'd16;
    end
    e = ref_out(wa, wb);
    @(negedge clk);
    a = pack(wa);
    b = pack(wb);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      n_cmp++;
      if (out_valid !== (c == 6)) begin
        $display("FAIL unity_latency: edge %0d out_valid=%b need %b",
                 c, out_valid, (c == 6));
        n_bad++;
      end
      if (c < 6) @(negedge clk);
    end
    n_cmp++;
    if (out !== e || out !== 9'd144) begin
      $display("FAIL unity_value: out=%0d need 144 (model %0d)", out, e);
      n_bad++;
    end
    model_out = 9'd144;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out !== model_out) begin
      $display("FAIL unity_pulse: out_valid=%b out=%h need 0/%h",
               out_valid, out, model_out);
      n_bad++;
    end
  endtask

  task automatic test_truncation();
    win_t wa;
    win_t wb;
    for (int k = 0; k < 9; k++) begin
      wa[k] = '0;
      wb[k] = '0;
    end
    wa[0] = 9'd1;
    wb[0] = 9'd1;
    apply_one(wa, wb);
    n_cmp++;
    if (out_valid !== 1'b1 || out !== 9'h000) begin
      $display("FAIL trunc_pos: out=%h v=%b need 000/1", out, out_valid);
      n_bad++;
    end
    wa[0] = 9'h1FF;
    apply_one(wa, wb);
    n_cmp++;
    if (out_valid !== 1'b1 || out !== 9'h1FF) begin
      $display("FAIL trunc_neg: out=%h v=%b need 1ff/1", out, out_valid);
      n_bad++;
    end
    model_out = 9'h1FF;
  endtask

  task automatic test_saturation();
    win_t wa;
    win_t wb;
    for (int k = 0; k < 9; k++) begin
      wa[k] = 9'd255;
      wb[k] = 9'd255;
    end
    apply_one(wa, wb);
    n_cmp++;
    if (out_valid !== 1'b1 || out !== 9'h0FF) begin
      $display("FAIL sat_pos: out=%h v=%b need 0ff/1", out, out_valid);
      n_bad++;
    end
    for (int k = 0; k < 9; k++) wa[k] = 9'h100;
    apply_one(wa, wb);
    n_cmp++;
    if (out_valid !== 1'b1 || out !== 9'h100) begin
      $display("FAIL sat_neg: out=%h v=%b need 100/1", out, out_valid);
      n_bad++;
    end
    model_out = 9'h100;
  endtask

  task automatic test_mixed_sign();
    win_t wa;
    win_t wb;
    for (int k = 0; k < 9; k++) begin
      wa[k] = W'((k + 1) * 16);
      wb[k] = (k % 2 == 0) ? 9'h1F0 : 9'd16;
    end
    apply_one(wa, wb);
    n_cmp++;
    if (out_valid !== 1'b1 || out !== 9'h1B0) begin
      $display("FAIL mixed_sign: out=%h v=%b need 1b0/1", out, out_valid);
      n_bad++;
    end
    model_out = 9'h1B0;
  endtask

  task automatic test_streaming();
    bit sched [$];
    logic [W-1:0] q [$];
    logic [W-1:0] e;
    win_t wa;
    win_t wb;
    int sent;
    int pulses;
    sched = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
              0, 1, 0, 0, 1, 0, 0, 0, 1};
    sent = 0;
    pulses = 0;
    @(negedge clk);
    for (int c = 0; c < sched.size() + 9; c++) begin
      if (out_valid === 1'b1) begin
        pulses++;
        n_cmp++;
        if (q.size() == 0) begin
          $display("FAIL stream_extra: unexpected out=%h", out);
          n_bad++;
        end else begin
          e = q.pop_front();
          if (out !== e) begin
            $display("FAIL stream_value: out=%h need %h", out, e);
            n_bad++;
          end
          model_out = e;
        end
      end else begin
        n_cmp++;
        if (out !== model_out) begin
          $display("FAIL stream_hold: out=%h need %h", out, model_out);
          n_bad++;
        end
      end
      wa = rand_win();
      wb = rand_win();
      a = pack(wa);
      b = pack(wb);
      in_valid = (c < sched.size()) ? sched[c] : 1'b0;
      if (in_valid) begin
        q.push_back(ref_out(wa, wb));
        sent++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (q.size() != 0 || pulses != sent) begin
      $display("FAIL stream_count: pulses=%0d need %0d left=%0d",
               pulses, sent, q.size());
      n_bad++;
    end
  endtask

  task automatic test_reset_midflight();
    win_t wa;
    win_t wb;
    logic [W-1:0] e;
    for (int i = 0; i < 7; i++) begin
      a = pack(rand_win());
      b = pack(rand_win());
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      $display("FAIL rst_pre: out_valid=%b need 1", out_valid);
      n_bad++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out !== 9'd0 || out_valid !== 1'b0) begin
      $display("FAIL rst_async: out=%h v=%b need 000/0", out, out_valid);
      n_bad++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_out = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || out !== model_out) begin
        $display("FAIL rst_flush: cyc %0d v=%b out=%h need 0/%h",
                 c, out_valid, out, model_out);
        n_bad++;
      end
    end
    wa = rand_win();
    wb = rand_win();
    e = ref_out(wa, wb);
    @(negedge clk);
    a = pack(wa);
    b = pack(wb);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      $display("FAIL rst_early: out_valid=%b need 0 at edge 5", out_valid);
      n_bad++;
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out !== e) begin
      $display("FAIL rst_resume: out=%h v=%b need %h/1", out, out_valid, e);
      n_bad++;
    end
    model_out = e;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_out = '0;
    test_reset();
    test_unity();
    test_truncation();
    test_saturation();
    test_mixed_sign();
    test_streaming();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
